// File: rtl/axis_pkt_pkg.sv
// Shared types and width helpers for the burst packetizer and its output queue.
package axis_pkt_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    typedef struct packed {
        logic                  last;
        logic                  dest;
        logic [DATA_W_DEF-1:0] data;
    } q_entry_t;

    // Index width for a range of n values; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the value n itself (occupancy counters).
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axis_pkt_queue.sv
// Small circular FIFO of {last, dest, data} whose head drives an AXI4-Stream master.
module axis_pkt_queue
    import axis_pkt_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk_tb,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic                     push_last,
    input  logic                     push_dest,
    input  logic [DATA_W-1:0]        push_data,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tdest,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     q_full,
    output logic                     q_empty
);
    localparam int unsigned PW = idx_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]  mem_last;
    logic [DEPTH-1:0]  mem_dest;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              pop;
    logic              push_ok;

    assign q_empty = (count == '0);
    assign q_full  = (count == CW'(DEPTH));
    assign pop     = m_axis_tvalid && m_axis_tready;
    // A push into a full queue is only taken when the head leaves in the same cycle.
    assign push_ok = push && (!q_full || pop);

    assign m_axis_tvalid = !q_empty;
    assign m_axis_tdata  = mem_data[rd_ptr];
    assign m_axis_tlast  = mem_last[rd_ptr];
    assign m_axis_tdest  = mem_dest[rd_ptr];

    always_ff @(posedge clk_tb) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
            end
            mem_last <= '0;
            mem_dest <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push_ok) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                mem_dest[wr_ptr] <= push_dest;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_burst_packetizer.sv
// FIFO-style write port to 32-bit AXI4-Stream with burst-length and idle-flush tlast insertion.
module axis_burst_packetizer
    import axis_pkt_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned BURST_WORDS   = 128,
    parameter int unsigned FLUSH_TIMEOUT = 256,
    parameter int unsigned Q_DEPTH       = 4,
    parameter int unsigned SWAP_CHANNELS = 0
) (
    input  logic              clk_tb,
    input  logic              aresetn,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tdest,
    output logic              overflow,
    output logic [15:0]       drop_cnt,
    output logic [31:0]       pkt_cnt
);
    localparam int unsigned  IW       = idx_w(BURST_WORDS);
    localparam int unsigned  TW       = idx_w(FLUSH_TIMEOUT);
    localparam logic [IW-1:0] LAST_IDX = IW'(BURST_WORDS - 1);
    localparam logic [TW-1:0] IDLE_MAX = TW'((FLUSH_TIMEOUT == 0) ? 0 : FLUSH_TIMEOUT - 1);

    logic                  hold_v;
    logic [DATA_W-1:0]     hold_d;
    logic [IW-1:0]         hold_idx;
    logic [IW-1:0]         run_idx;
    logic [IW-1:0]         next_run;
    logic [IW-1:0]         new_idx;
    logic [TW-1:0]         idle;
    logic                  dest_q;
    logic                  q_full;
    logic                  q_empty;
    logic [cnt_w(Q_DEPTH)-1:0] q_count;
    logic                  unused_q;
    logic                  pop;
    logic                  accept;
    logic                  is_last_idx;
    logic                  flush_cond;
    logic                  push;
    logic                  push_last;

    assign unused_q    = ^{q_count, q_empty};
    assign full        = hold_v && q_full;
    assign accept      = write && !full;
    assign pop         = m_axis_tvalid && m_axis_tready;
    assign is_last_idx = (hold_idx == LAST_IDX);
    assign flush_cond  = (FLUSH_TIMEOUT != 0) && hold_v && (idle == IDLE_MAX);
    assign push_last   = is_last_idx || flush_cond;
    // An accepted write with hold occupied always has a slot, since full would block it.
    assign push        = hold_v && (accept || is_last_idx || flush_cond) && (!q_full || pop);
    assign next_run    = push_last ? '0 : hold_idx + 1'b1;

    always_comb begin
        new_idx = run_idx;
        if (hold_v) begin
            new_idx = next_run;
        end
    end

    always_ff @(posedge clk_tb) begin
        if (!aresetn) begin
            hold_v   <= 1'b0;
            hold_d   <= '0;
            hold_idx <= '0;
            run_idx  <= '0;
            idle     <= '0;
            dest_q   <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (accept) begin
                hold_v   <= 1'b1;
                hold_d   <= data_in;
                hold_idx <= new_idx;
            end else if (push) begin
                hold_v <= 1'b0;
            end
            if (push) begin
                run_idx <= next_run;
            end
            if (accept || push) begin
                idle <= '0;
            end else if (hold_v && idle != IDLE_MAX) begin
                idle <= idle + 1'b1;
            end
            if (push && push_last && SWAP_CHANNELS != 0) begin
                dest_q <= ~dest_q;
            end
            if (write && full) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
            if (pop && m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

    axis_pkt_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (Q_DEPTH)
    ) u_queue (
        .clk_tb        (clk_tb),
        .aresetn       (aresetn),
        .push          (push),
        .push_last     (push_last),
        .push_dest     (dest_q),
        .push_data     (hold_d),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .count         (q_count),
        .q_full        (q_full),
        .q_empty       (q_empty)
    );

endmodule

// File: tb/tb_axis_burst_packetizer.sv
// Scoreboard bench: the driver predicts each beat into a queue, the monitor pops and compares.
module tb_axis_burst_packetizer;
    import axis_pkt_pkg::*;

    localparam int unsigned BW = 128;
    localparam int unsigned FT = 16;
    localparam int unsigned QD = 4;

    logic        clk_tb        = 1'b0;
    logic        aresetn       = 1'b0;
    logic        write         = 1'b0;
    logic [31:0] data_in       = '0;
    logic        m_axis_tready = 1'b0;
    logic        full;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tdest;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [31:0] pkt_cnt;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    q_entry_t    exp_q[$];
    int unsigned m_idx  = 0;
    logic        m_dest = 1'b0;

    logic        stall_v = 1'b0;
    q_entry_t    stall_e;

    axis_burst_packetizer #(
        .DATA_W        (32),
        .BURST_WORDS   (BW),
        .FLUSH_TIMEOUT (FT),
        .Q_DEPTH       (QD),
        .SWAP_CHANNELS (1)
    ) dut (
        .clk_tb        (clk_tb),
        .aresetn       (aresetn),
        .write         (write),
        .data_in       (data_in),
        .full          (full),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt),
        .pkt_cnt       (pkt_cnt)
    );

    always #5 clk_tb = ~clk_tb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic model_accept(input logic [31:0] d);
        q_entry_t e;
        e.last = (m_idx == BW - 1);
        e.dest = m_dest;
        e.data = d;
        exp_q.push_back(e);
        if (e.last) begin
            m_idx  = 0;
            m_dest = ~m_dest;
        end else begin
            m_idx++;
        end
    endtask

    // The word still in hold will be closed by the idle timeout.
    task automatic model_flush();
        q_entry_t e;
        e = exp_q.pop_back();
        e.last = 1'b1;
        exp_q.push_back(e);
        m_idx  = 0;
        m_dest = ~m_dest;
    endtask

    task automatic write_seq(input int unsigned base, input int unsigned n, input bit rnd_ready);
        int unsigned sent  = 0;
        int unsigned guard = 0;
        while (sent < n && guard < 20000) begin
            if (rnd_ready) m_axis_tready = ($urandom_range(1, 0) == 1) || (guard % 8 == 0);
            if (!full) begin
                write   = 1'b1;
                data_in = base + sent;
                model_accept(base + sent);
                sent++;
            end else begin
                write = 1'b0;
            end
            tick();
            guard++;
        end
        write = 1'b0;
        chk("write_budget", 64'(sent), 64'(n));
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        m_axis_tready = 1'b1;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_tvalid"},   64'(m_axis_tvalid), 64'd0);
        chk({tag, "_tlast"},    64'(m_axis_tlast),  64'd0);
        chk({tag, "_tdest"},    64'(m_axis_tdest),  64'd0);
        chk({tag, "_tdata"},    64'(m_axis_tdata),  64'd0);
        chk({tag, "_full"},     64'(full),          64'd0);
        chk({tag, "_overflow"}, 64'(overflow),      64'd0);
        chk({tag, "_drop_cnt"}, 64'(drop_cnt),      64'd0);
        chk({tag, "_pkt_cnt"},  64'(pkt_cnt),       64'd0);
    endtask

    // Monitor: handshakes are sampled mid-cycle and take effect at the next rising edge.
    always @(negedge clk_tb) begin
        if (!aresetn) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                if (m_axis_tvalid) chk("stable_under_backpressure",
                                       64'({m_axis_tlast, m_axis_tdest, m_axis_tdata}), 64'(stall_e));
                else               chk("tvalid_dropped_without_handshake", 64'd0, 64'd1);
            end
            stall_v = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(m_axis_tdata), 64'hDEAD_0000_0000_0000);
                end else begin
                    q_entry_t e;
                    e = exp_q.pop_front();
                    chk("beat", 64'({m_axis_tlast, m_axis_tdest, m_axis_tdata}), 64'(e));
                end
            end else if (m_axis_tvalid) begin
                stall_v = 1'b1;
                stall_e = {m_axis_tlast, m_axis_tdest, m_axis_tdata};
            end
        end
    end

    initial begin
        int unsigned lat;
        int unsigned acc;

        aresetn = 1'b0;
        repeat (3) tick();
        check_zero_outputs("reset");
        aresetn = 1'b1;
        tick();

        // Two full packets back to back.
        m_axis_tready = 1'b1;
        write_seq(0, 256, 0);
        drain("drain_256");
        chk("pkt_cnt_256",  64'(pkt_cnt),  64'd2);
        chk("drop_cnt_256", 64'(drop_cnt), 64'd0);
        chk("overflow_256", 64'(overflow), 64'd0);

        // Three packets alternating channel 0,1,0.
        write_seq(32'h1_0000, 3 * BW, 0);
        drain("drain_swap");
        chk("pkt_cnt_swap", 64'(pkt_cnt), 64'd5);

        // Partial packet closed by idle timeout.
        write_seq(0, 10, 0);
        model_flush();
        lat = 0;
        while (!(m_axis_tvalid && m_axis_tlast) && lat < 40) begin
            tick();
            lat++;
        end
        chk("flush_latency", 64'(lat), 64'(FT));
        repeat (20) tick();
        chk("idle_after_flush_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("pkt_cnt_flush", 64'(pkt_cnt), 64'd6);
        chk("flush_queue_empty", 64'(exp_q.size()), 64'd0);

        // Back-pressure overflow: 4 queue slots plus the holding register.
        m_axis_tready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            write   = 1'b1;
            data_in = 32'd2000 + 32'(i);
            if (!full) begin
                model_accept(32'd2000 + 32'(i));
                acc++;
            end
            tick();
        end
        write = 1'b0;
        chk("accepted_before_full", 64'(acc),      64'd5);
        chk("full_asserted",        64'(full),     64'd1);
        chk("overflow_sticky",      64'(overflow), 64'd1);
        chk("drop_cnt_15",          64'(drop_cnt), 64'd15);
        model_flush();
        drain("drain_overflow");
        chk("pkt_cnt_overflow", 64'(pkt_cnt), 64'd7);
        chk("full_cleared",     64'(full),    64'd0);

        // Random ready with a producer that honours full.
        write_seq(32'h5000, 300, 1);
        model_flush();
        drain("drain_random");
        chk("pkt_cnt_random",  64'(pkt_cnt),  64'd10);
        chk("drop_cnt_random", 64'(drop_cnt), 64'd15);

        // Reset in the middle of a packet discards buffered words.
        m_axis_tready = 1'b1;
        write_seq(32'h7000, 61, 0);
        aresetn = 1'b0;
        exp_q.delete();
        m_idx  = 0;
        m_dest = 1'b0;
        tick();
        check_zero_outputs("midreset");
        aresetn = 1'b1;
        tick();
        write_seq(32'h9000, BW, 0);
        drain("drain_post_reset");
        chk("pkt_cnt_post_reset", 64'(pkt_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
